complete_cdb_arbiter: RTL

- Complete stage of the 3-wide R10K pipeline.
- Each functional unit (FU) hands over one result per cycle into a one-entry holding buffer.
- Each cycle a round-robin arbiter grants up to 3 buffered results onto the CDB through a register.
- Registered CDB drives the physical register file write port (tags + data), RS wakeup and ROB completion.

---
 rtl/complete_cdb_arbiter_pkg.sv | 35 +++
 rtl/complete_cdb_arbiter_rr_pick3.sv | 47 ++++
 rtl/complete_cdb_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/complete_cdb_arbiter_pkg.sv
// Shared types for the complete stage: CDB tag packet, per-FU result packet,
// physical register / data widths and the zero (no-destination) register.
package complete_cdb_arbiter_pkg;

   localparam int PHYS_REG_W   = 6;
   localparam int XLEN         = 32;
   localparam int ROB_IDX_BITS = 5;

   localparam logic [PHYS_REG_W-1:0] ZERO_PHYS_REG = '0;

   typedef struct packed {
      logic [PHYS_REG_W-1:0] t0;
      logic [PHYS_REG_W-1:0] t1;
      logic [PHYS_REG_W-1:0] t2;
   } CDB_T_PACKET;

   typedef struct packed {
      logic [PHYS_REG_W-1:0]   tag;
      logic [XLEN-1:0]         data;
      logic [ROB_IDX_BITS-1:0] rob_idx;
   } FU_RESULT_PACKET;

   // Index of the set bit in a one-hot vector of up to eight requesters.
   function automatic logic [2:0] onehot8_to_idx(input logic [7:0] v);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) begin
            idx = 3'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/complete_cdb_arbiter_rr_pick3.sv
// Rotating-priority picker: the first three full buffers found scanning from
// the round-robin pointer get lanes 0, 1 and 2 (one-hot grant per lane).
module rr_pick3 #(
   parameter  int NUM_FU = 5,
   localparam int IDX_W  = $clog2(NUM_FU)
) (
   input  logic [NUM_FU-1:0] i_full,
   input  logic [IDX_W-1:0]  i_rr_ptr,
   output logic [NUM_FU-1:0] o_grant0,
   output logic [NUM_FU-1:0] o_grant1,
   output logic [NUM_FU-1:0] o_grant2,
   output logic [2:0]        o_lane_valid
);

   localparam int SUM_W = IDX_W + 1;

   logic [2:0][NUM_FU-1:0] w_grant;

   // The sum needs one extra bit so the wrap back below NUM_FU is a single subtract.
   always_comb begin
      logic [SUM_W-1:0] sum;
      logic [IDX_W-1:0] idx;
      logic [1:0]       cnt;
      w_grant      = '0;
      o_lane_valid = '0;
      cnt          = '0;
      sum          = '0;
      idx          = '0;
      for (int off = 0; off < NUM_FU; off++) begin
         sum = {1'b0, i_rr_ptr} + SUM_W'(off);
         if (sum >= SUM_W'(NUM_FU)) begin
            sum = sum - SUM_W'(NUM_FU);
         end
         idx = sum[IDX_W-1:0];
         if (i_full[idx] && (cnt < 2'd3)) begin
            w_grant[cnt][idx] = 1'b1;
            o_lane_valid[cnt] = 1'b1;
            cnt               = cnt + 2'd1;
         end
      end
   end

   assign o_grant0 = w_grant[0];
   assign o_grant1 = w_grant[1];
   assign o_grant2 = w_grant[2];

endmodule

// File: rtl/complete_cdb_arbiter.sv
// Complete stage: one-entry holding buffer per FU, round-robin grant of up to
// three results per cycle, and the registered 3-lane CDB.
module complete_cdb_arbiter
   import complete_cdb_arbiter_pkg::*;
#(
   parameter int NUM_FU    = 5,
   parameter int ROB_IDX_W = 5,
   parameter int CDB_W     = 3
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 squash,
   input  logic [NUM_FU-1:0]                    fu_valid,
   input  logic [NUM_FU-1:0][PHYS_REG_W-1:0]    fu_tag,
   input  logic [NUM_FU-1:0][XLEN-1:0]          fu_data,
   input  logic [NUM_FU-1:0][ROB_IDX_W-1:0]     fu_rob_idx,
   output logic [NUM_FU-1:0]                    fu_ready,
   output logic [CDB_W-1:0]                     cdb_valid,
   output CDB_T_PACKET                          cdb_tag,
   output logic [CDB_W-1:0][XLEN-1:0]           cdb_data,
   output logic [CDB_W-1:0][ROB_IDX_W-1:0]      cdb_rob_idx
);

   localparam int IDX_W = $clog2(NUM_FU);

   FU_RESULT_PACKET [NUM_FU-1:0]      r_buf;
   logic [NUM_FU-1:0]                 r_full;
   logic [IDX_W-1:0]                  r_rr_ptr;
   logic [CDB_W-1:0]                  r_cdb_valid;
   CDB_T_PACKET                       r_cdb_tag;
   logic [CDB_W-1:0][XLEN-1:0]        r_cdb_data;
   logic [CDB_W-1:0][ROB_IDX_W-1:0]   r_cdb_rob_idx;

   logic [NUM_FU-1:0]                 w_grant0;
   logic [NUM_FU-1:0]                 w_grant1;
   logic [NUM_FU-1:0]                 w_grant2;
   logic [2:0][NUM_FU-1:0]            w_grants;
   logic [NUM_FU-1:0]                 w_grant_any;
   logic [2:0]                        w_lane_valid;
   logic [NUM_FU-1:0]                 w_accept;
   FU_RESULT_PACKET [CDB_W-1:0]       w_lane_pkt;
   logic [IDX_W-1:0]                  w_last_idx;
   logic [IDX_W-1:0]                  w_next_ptr;

   rr_pick3 #(
      .NUM_FU (NUM_FU)
   ) u_pick (
      .i_full       (r_full),
      .i_rr_ptr     (r_rr_ptr),
      .o_grant0     (w_grant0),
      .o_grant1     (w_grant1),
      .o_grant2     (w_grant2),
      .o_lane_valid (w_lane_valid)
   );

   assign w_grants    = {w_grant2, w_grant1, w_grant0};
   assign w_grant_any = w_grant0 | w_grant1 | w_grant2;

   // A buffer being drained onto the CDB this cycle can take a new result at the same edge.
   assign fu_ready = {NUM_FU{rst && !squash}} & (~r_full | w_grant_any);
   assign w_accept = fu_valid & fu_ready;

   always_ff @(posedge clk) begin
      if (!rst || squash) begin
         r_full <= '0;
      end else begin
         r_full <= w_accept | (r_full & ~w_grant_any);
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_FU; i++) begin
         if (w_accept[i]) begin
            r_buf[i] <= '{tag:     fu_tag[i],
                          data:    fu_data[i],
                          rob_idx: ROB_IDX_BITS'(fu_rob_idx[i])};
         end
      end
   end

   // The pointer moves past the last buffer granted, found from the highest valid lane.
   always_comb begin
      w_last_idx = '0;
      if (w_lane_valid[2]) begin
         w_last_idx = IDX_W'(onehot8_to_idx(8'(w_grant2)));
      end else if (w_lane_valid[1]) begin
         w_last_idx = IDX_W'(onehot8_to_idx(8'(w_grant1)));
      end else begin
         w_last_idx = IDX_W'(onehot8_to_idx(8'(w_grant0)));
      end
      if (w_last_idx == IDX_W'(NUM_FU - 1)) begin
         w_next_ptr = '0;
      end else begin
         w_next_ptr = w_last_idx + IDX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rr_ptr <= '0;
      end else if (!squash && (|w_lane_valid)) begin
         r_rr_ptr <= w_next_ptr;
      end
   end

   always_comb begin
      w_lane_pkt = '0;
      for (int k = 0; k < CDB_W; k++) begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (w_grants[k][i]) begin
               w_lane_pkt[k] = r_buf[i];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst || squash) begin
         r_cdb_valid   <= '0;
         r_cdb_tag     <= '{t0: ZERO_PHYS_REG, t1: ZERO_PHYS_REG, t2: ZERO_PHYS_REG};
         r_cdb_data    <= '0;
         r_cdb_rob_idx <= '0;
      end else begin
         r_cdb_valid  <= w_lane_valid;
         r_cdb_tag.t0 <= w_lane_valid[0] ? w_lane_pkt[0].tag : ZERO_PHYS_REG;
         r_cdb_tag.t1 <= w_lane_valid[1] ? w_lane_pkt[1].tag : ZERO_PHYS_REG;
         r_cdb_tag.t2 <= w_lane_valid[2] ? w_lane_pkt[2].tag : ZERO_PHYS_REG;
         for (int k = 0; k < CDB_W; k++) begin
            r_cdb_data[k]    <= w_lane_pkt[k].data;
            r_cdb_rob_idx[k] <= ROB_IDX_W'(w_lane_pkt[k].rob_idx);
         end
      end
   end

   assign cdb_valid   = r_cdb_valid;
   assign cdb_tag     = r_cdb_tag;
   assign cdb_data    = r_cdb_data;
   assign cdb_rob_idx = r_cdb_rob_idx;

endmodule
